player_input: RTL and testbench
===============================

// Module: player_input
// PURPOSE
// - Conditions the raw board buttons into the clean control levels that the player movement block consumes.
// - Outputs: left/right movement levels and a fire request for the bullet logic.
// - Each button is synchronised, then debounced; left/right conflicts are resolved to "no move".
// - A button press becomes a single-shot fire request, held until bullet logic acknowledges it.
// PARAMETERS
// - DEBOUNCE_CYCLES  250000  consecutive stable cycles needed to accept a level change (10 ms @ 25 MHz); legal range 1..2**CNT_W-1
// - CNT_W            18      width of each debounce counter
// PORTS
// - clk           in   1  system clock; single clock domain
// - rst_n         in   1  synchronous active-low reset
// - btn_left      in   1  raw left button, asynchronous, active-high, bouncy
// - btn_right     in   1  raw right button, asynchronous, active-high, bouncy
// - btn_fire      in   1  raw fire button, asynchronous, active-high, bouncy
// - fire_ack      in   1  bullet logic accepted the pending request (sampled at posedge)
// - left          out  1  debounced move-left level
// - right         out  1  debounced move-right level
// - fire_req      out  1  pending fire request
// BEHAVIOUR
// - Reset: when rst_n=0 at a posedge, every register clears. This covers sync flops, debounced states, counters, fire_req, and the previous-fire register. left=right=fire_req=0.
// - Reset in mid-operation discards partial counts and any pending request.
// - Synchroniser: 2-flop chain per button (s1 <= raw; s2 <= s1).
// - Debouncer, per button: a stable register db and a counter cnt[CNT_W-1:0].
//   - s2==db: cnt <= 0.
//   - s2!=db and cnt==DEBOUNCE_CYCLES-1: db <= s2, cnt <= 0.
//   - s2!=db otherwise: cnt <= cnt+1.
//   - Consequently a glitch shorter than DEBOUNCE_CYCLES cycles at s2 never changes db.
// - Latency: number the posedge that first samples a new, stable raw value as edge 1. db, and therefore the output, changes at edge DEBOUNCE_CYCLES+2.
// - Movement outputs are registered, from the current db values:
//   - left  <= db_l & ~db_r
//   - right <= db_r & ~db_l
//   - Both pressed gives both 0; neither pressed gives both 0.
//   - These registers add one cycle, so the total raw-to-left/right latency is DEBOUNCE_CYCLES+3 edges.
// - Fire edge detect: db_f_q <= db_f. Define rise = db_f & ~db_f_q, a one-cycle pulse per accepted press.
//   - Holding the button produces no auto-repeat; it must be released (debounced) and pressed again.
// - Fire request state machine, two states:
//   - IDLE (fire_req=0): rise moves to PEND.
//   - PEND (fire_req=1): fire_ack moves to IDLE, unless rise occurs in the same cycle, which keeps PEND (set has priority).
//   - rise while in PEND without ack stays in PEND; the press is dropped (depth-1, no queue).
//   - fire_ack while in IDLE is ignored.
// - Within this block, fire_req asserts one cycle after rise. Total raw-to-fire_req latency is DEBOUNCE_CYCLES+3 edges.
// - Button held through reset release: db starts at 0. The held level is accepted after DEBOUNCE_CYCLES+2 edges. For fire, this yields one request (defined behaviour).
// - Counters never wrap: they clear at DEBOUNCE_CYCLES-1 on acceptance, or on any s2==db cycle.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
// - Reset: hold rst_n=0 for 3 cycles with all buttons high.
//   - Required: left=right=fire_req=0 throughout reset.
//   - Required: 6 edges after release, left and right remain 0 (both pressed); fire_req=1 at edge 7.
// - Clean press: btn_left 0->1 and held.
//   - Required: left=1 first visible after edge 7.
//   - Required: release gives left=0 after another 7 edges.
// - Bounce rejection: btn_right toggles every 2 cycles for 20 cycles, then holds at 0.
//   - Required: right stays 0 the whole time, and fire_req stays 0.
// - Conflict: left held accepted (left=1), then btn_right pressed.
//   - Required: 7 edges later left=0 and right=0.
//   - Then release btn_left: right=1 7 edges after that.
// - Fire handshake: press fire and hold 30 cycles, no ack.
//   - Required: fire_req=1 and stays 1.
//   - Pulse fire_ack for 1 cycle: fire_req=0 next cycle and stays 0 while held.
//   - Release then press again: fire_req=1 again.
// - Simultaneous set/ack: arrange rise coincident with fire_ack while in PEND.
//   - Required: fire_req stays 1.
//   - Assert rst_n=0 mid-debounce (cnt=2): required: all outputs 0 and no request afterwards for a released button.

Source files
------------

// File: rtl/player_input.sv
// player_input: synchronise and debounce buttons into move levels and a held fire request
module player_input #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_fire,
    input  logic fire_ack,
    output logic left,
    output logic right,
    output logic fire_req
);
    typedef enum logic {IDLE, PEND} state_t;
    state_t state, state_nxt;
    logic [2:0] raw, s1, s2, db;
    logic db_f_q, rise;

    assign raw = {btn_fire, btn_right, btn_left};

    // two-flop synchroniser per button
    always_ff @(posedge clk)
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end

    for (genvar i = 0; i < 3; i++) begin : g_db
        logic [CNT_W-1:0] cnt;
        logic             lvl;
        // accept a new level only once it has held for DEBOUNCE_CYCLES cycles
        always_ff @(posedge clk)
            if (!rst_n) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (s2[i] == lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                lvl <= s2[i];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        assign db[i] = lvl;
    end

    // registered movement levels with conflict cancel, and fire history for edge detect
    always_ff @(posedge clk)
        if (!rst_n) begin
            left   <= 1'b0;
            right  <= 1'b0;
            db_f_q <= 1'b0;
        end else begin
            left   <= db[0] & ~db[1];
            right  <= db[1] & ~db[0];
            db_f_q <= db[2];
        end

    assign rise = db[2] & ~db_f_q;

    // fire request state register
    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    // a new press sets the request and wins over a same-cycle acknowledge
    always_comb
        state_nxt = rise ? PEND : (state == PEND && fire_ack) ? IDLE : state;

    assign fire_req = (state == PEND);
endmodule

// File: tb/tb_player_input.sv
// tb_player_input: scoreboard bench for player_input with directed button sequences
module tb_player_input;
    logic clk = 1'b0;
    logic rst_n, btn_left, btn_right, btn_fire, fire_ack;
    logic left, right, fire_req;

    typedef struct {
        int         cyc;
        string      nm;
        logic [2:0] v;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    player_input #(.DEBOUNCE_CYCLES(4), .CNT_W(18)) dut (
        .clk(clk), .rst_n(rst_n), .btn_left(btn_left), .btn_right(btn_right),
        .btn_fire(btn_fire), .fire_ack(fire_ack),
        .left(left), .right(right), .fire_req(fire_req)
    );

    always #5 clk = ~clk;

    // count posedges so expectations can be tagged with the cycle they apply to
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: compare every expectation due at this cycle, away from the active edge
    always @(negedge clk)
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_chk++;
            if (e.cyc != cyc || {left, right, fire_req} !== e.v) begin
                n_fail++;
                $display("FAIL %s cyc=%0d (due %0d): left/right/fire_req=%b required %b",
                         e.nm, cyc, e.cyc, {left, right, fire_req}, e.v);
            end
        end

    task automatic exp_range(input int a, input int b, input string nm, input logic [2:0] v);
        for (int k = a; k <= b; k++) q.push_back('{cyc + k, nm, v});
    endtask

    task automatic wt(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; btn_left = 1'b1; btn_right = 1'b1; btn_fire = 1'b1; fire_ack = 1'b0;
        exp_range(1, 3, "in_reset", 3'b000);
        wt(3);
        rst_n = 1'b1;
        exp_range(1, 6, "post_reset_hold", 3'b000);
        exp_range(7, 7, "post_reset_fire", 3'b001);
        wt(8);
        btn_left = 1'b0; btn_right = 1'b0; btn_fire = 1'b0; fire_ack = 1'b1;
        exp_range(1, 10, "ack_and_release", 3'b000);
        wt(1);
        fire_ack = 1'b0;
        wt(9);
        btn_left = 1'b1;
        exp_range(1, 6, "left_latency", 3'b000);
        exp_range(7, 10, "left_pressed", 3'b100);
        wt(10);
        btn_left = 1'b0;
        exp_range(1, 6, "left_release_latency", 3'b100);
        exp_range(7, 9, "left_released", 3'b000);
        wt(10);
        for (int i = 0; i < 10; i++) begin
            btn_right = ~btn_right;
            exp_range(1, 1, "bounce", 3'b000);
            wt(1);
            exp_range(1, 1, "bounce", 3'b000);
            wt(1);
        end
        for (int i = 0; i < 10; i++) begin
            exp_range(1, 1, "bounce_settle", 3'b000);
            wt(1);
        end
        btn_left = 1'b1;
        exp_range(1, 6, "conflict_left_wait", 3'b000);
        exp_range(7, 7, "conflict_left", 3'b100);
        wt(8);
        btn_right = 1'b1;
        exp_range(1, 6, "conflict_pending", 3'b100);
        exp_range(7, 7, "conflict_both", 3'b000);
        wt(8);
        btn_left = 1'b0;
        exp_range(1, 6, "conflict_release_wait", 3'b000);
        exp_range(7, 7, "conflict_right", 3'b010);
        wt(8);
        btn_right = 1'b0;
        exp_range(1, 6, "right_release_wait", 3'b010);
        exp_range(7, 8, "right_released", 3'b000);
        wt(8);
        btn_fire = 1'b1;
        exp_range(1, 6, "fire_latency", 3'b000);
        exp_range(7, 30, "fire_held", 3'b001);
        wt(30);
        fire_ack = 1'b1;
        exp_range(1, 6, "fire_acked_held", 3'b000);
        wt(1);
        fire_ack = 1'b0;
        wt(5);
        btn_fire = 1'b0;
        exp_range(1, 9, "fire_release", 3'b000);
        wt(9);
        btn_fire = 1'b1;
        exp_range(1, 6, "fire_again_wait", 3'b000);
        exp_range(7, 7, "fire_again", 3'b001);
        wt(8);
        btn_fire = 1'b0;
        exp_range(1, 8, "pend_release", 3'b001);
        wt(8);
        btn_fire = 1'b1;
        exp_range(1, 10, "set_ack_collide", 3'b001);
        wt(6);
        fire_ack = 1'b1;
        wt(1);
        fire_ack = 1'b0;
        wt(4);
        fire_ack = 1'b1;
        exp_range(1, 3, "plain_ack", 3'b000);
        wt(1);
        fire_ack = 1'b0;
        wt(3);
        btn_fire = 1'b0;
        exp_range(1, 9, "pre_midreset_release", 3'b000);
        wt(9);
        btn_left = 1'b1; btn_fire = 1'b1;
        exp_range(1, 4, "mid_debounce", 3'b000);
        wt(4);
        rst_n = 1'b0; btn_left = 1'b0; btn_fire = 1'b0;
        exp_range(1, 12, "mid_reset", 3'b000);
        wt(2);
        rst_n = 1'b1;
        wt(10);
        for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
